delay_sum_beamformer: RTL and testbench

Parametrised multi-channel delay-and-sum beamformer, the successor to the single-channel index-match sample picker. Consumes one indexed multi-channel sample stream. For each focal point, captures each channel's sample at that channel's programmed target index, then emits the signed sum of all channels. A runtime-loadable delay table holds one target index per (point, channel); it sits between the acquisition front end and the output buffer.

---
 rtl/beamformer_pkg.sv | 21 ++
 rtl/bf_channel_capture.sv | 53 +++++
 rtl/delay_sum_beamformer.sv | 152 +++++++++++++++
 tb/tb_delay_sum_beamformer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beamformer_pkg.sv
// Shared definitions for the delay-and-sum beamformer: default geometry,
// frame FSM encoding and the output sum width.
package beamformer_pkg;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_IDX_W      = 16;
    localparam int DEF_NUM_POINTS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bf_state_t;

    // Growth bits for summing num_ch signed samples without overflow.
    function automatic int sum_width(input int num_ch, input int data_w);
        return data_w + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/bf_channel_capture.sv
// One receive channel: holds the captured flag and sample for the current
// focal point and decides match (capture) or miss (target index passed).
module bf_channel_capture
    import beamformer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     sample,
    input  logic [IDX_W-1:0]         index,
    input  logic [IDX_W-1:0]         target,
    input  logic signed [DATA_W-1:0] data,
    output logic                     flag_next,
    output logic signed [DATA_W-1:0] capt_next,
    output logic                     miss
);

    logic                     flag_q;
    logic signed [DATA_W-1:0] capt_q;
    logic                     hit;
    logic                     passed;

    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path leaves a value unassigned and no latch forms.
    always_comb begin
        hit       = sample && !flag_q && (index == target);
        passed    = sample && !flag_q && (index > target);
        miss      = passed;
        flag_next = flag_q || hit || passed;
        capt_next = capt_q;
        if (hit) begin
            capt_next = data;
        end else if (passed) begin
            capt_next = '0;
        end
    end

    // NOTE: clocked state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            flag_q <= 1'b0;
            capt_q <= '0;
        end else begin
            flag_q <= flag_next;
            capt_q <= capt_next;
        end
    end

endmodule

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: per focal point, captures every channel at its
// programmed sample index and emits the signed sum of all channels.
module delay_sum_beamformer
    import beamformer_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int NUM_POINTS = DEF_NUM_POINTS
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic                                         in_valid,
    input  logic [IDX_W-1:0]                             in_index,
    input  logic [NUM_CH*DATA_W-1:0]                     in_data,
    input  logic                                         cfg_we,
    input  logic [$clog2(NUM_POINTS*NUM_CH)-1:0]         cfg_addr,
    input  logic [IDX_W-1:0]                             cfg_data,
    output logic                                         out_valid,
    output logic signed [sum_width(NUM_CH, DATA_W)-1:0]  out_sum,
    output logic [$clog2(NUM_POINTS)-1:0]                out_point,
    output logic                                         frame_done,
    output logic                                         busy,
    output logic                                         miss_err
);

    localparam int DEPTH  = NUM_POINTS * NUM_CH;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PT_W   = $clog2(NUM_POINTS);
    localparam int SUM_W  = sum_width(NUM_CH, DATA_W);

    bf_state_t                state_q;
    bf_state_t                state_d;
    logic [PT_W-1:0]          point_q;
    logic [IDX_W-1:0]         last_idx_q;
    logic                     last_valid_q;
    logic [IDX_W-1:0]         delay_table [DEPTH];
    logic [ADDR_W-1:0]        row_base;
    logic                     addr_ok;
    logic                     accept;
    logic                     all_next;
    logic                     complete;
    logic                     last_point;
    logic                     chan_clear;
    logic [NUM_CH-1:0]        flag_next;
    logic [NUM_CH-1:0]        miss;
    logic signed [DATA_W-1:0] capt_next [NUM_CH];
    logic signed [SUM_W-1:0]  sum_next;

    if (DEPTH == (1 << ADDR_W)) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_part
        assign addr_ok = (int'(cfg_addr) < DEPTH);
    end

    // NOTE: the delay table is bulk storage with no reset, so it can map onto
    // plain register files or RAM; software loads it before each use.
    always_ff @(posedge clk) begin
        if (!reset && cfg_we && addr_ok && state_q == ST_IDLE) begin
            delay_table[cfg_addr] <= cfg_data;
        end
    end

    // A repeated index is the same sample re-presented, never a new one.
    assign accept     = (state_q == ST_RUN) && start && in_valid &&
                        (!last_valid_q || in_index != last_idx_q);
    assign all_next   = &flag_next;
    assign complete   = accept && all_next;
    assign last_point = (point_q == PT_W'(NUM_POINTS - 1));
    assign chan_clear = (state_q != ST_RUN) || !start || complete;
    assign row_base   = ADDR_W'(int'(point_q) * NUM_CH);
    assign busy       = (state_q == ST_RUN);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        bf_channel_capture #(
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W)
        ) u_capture (
            .clk       (clk),
            .reset     (reset),
            .clear     (chan_clear),
            .sample    (accept),
            .index     (in_index),
            .target    (delay_table[row_base + ADDR_W'(c)]),
            .data      (in_data[c*DATA_W +: DATA_W]),
            .flag_next (flag_next[c]),
            .capt_next (capt_next[c]),
            .miss      (miss[c])
        );
    end

    // Channels capturing on this edge contribute the live sample.
    always_comb begin
        sum_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum_next = sum_next + SUM_W'(capt_next[c]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (complete && last_point) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (!start) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            point_q      <= '0;
            last_idx_q   <= '0;
            last_valid_q <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_point    <= '0;
            frame_done   <= 1'b0;
            miss_err     <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_valid  <= complete;
            frame_done <= complete && last_point;
            if (complete) begin
                out_sum   <= sum_next;
                out_point <= point_q;
                point_q   <= last_point ? '0 : point_q + 1'b1;
            end
            if (state_q == ST_IDLE && start) begin
                point_q      <= '0;
                last_valid_q <= 1'b0;
                miss_err     <= 1'b0;
            end else if (state_q == ST_RUN && !start) begin
                point_q <= '0;
            end
            if (accept) begin
                last_valid_q <= 1'b1;
                last_idx_q   <= in_index;
                if (|miss) miss_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Directed bench for delay_sum_beamformer: a frame-level model predicts the
// outputs every cycle, and literal expectations pin the model on key cases.
module tb_delay_sum_beamformer;

    localparam int NUM_CH     = 4;
    localparam int DATA_W     = 16;
    localparam int IDX_W      = 16;
    localparam int NUM_POINTS = 16;
    localparam int DEPTH      = NUM_POINTS * NUM_CH;

    logic                     clk = 1'b0;
    logic                     reset, start, in_valid, cfg_we;
    logic [IDX_W-1:0]         in_index, cfg_data;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [5:0]               cfg_addr;
    logic                     out_valid, frame_done, busy, miss_err;
    logic signed [17:0]       out_sum;
    logic [3:0]               out_point;

    int n_checks = 0;
    int n_errors = 0;

    delay_sum_beamformer #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_POINTS(NUM_POINTS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_index(in_index), .in_data(in_data), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .out_valid(out_valid),
        .out_sum(out_sum), .out_point(out_point), .frame_done(frame_done),
        .busy(busy), .miss_err(miss_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Frame-level model: mode flags, table copy and per-point capture lists.
    int     tbl [DEPTH];
    bit     m_run, m_done, m_have_last;
    int     m_point, m_last;
    bit     m_got [NUM_CH];
    longint m_cap [NUM_CH];
    bit     exp_valid, exp_frame_done, exp_busy, exp_miss;
    longint exp_sum;
    int     exp_point;

    always @(posedge clk) begin
        exp_valid      = 0;
        exp_frame_done = 0;
        if (reset) begin
            m_run = 0; m_done = 0; m_have_last = 0; m_point = 0; m_last = 0;
            foreach (m_got[c]) begin m_got[c] = 0; m_cap[c] = 0; end
            exp_sum = 0; exp_point = 0; exp_miss = 0;
        end else if (m_done) begin
            if (!start) m_done = 0;
        end else if (!m_run) begin
            if (cfg_we && int'(cfg_addr) < DEPTH) tbl[cfg_addr] = int'(cfg_data);
            if (start) begin
                m_run = 1; m_point = 0; m_have_last = 0; exp_miss = 0;
                foreach (m_got[c]) m_got[c] = 0;
            end
        end else if (!start) begin
            m_run = 0; m_point = 0;
            foreach (m_got[c]) m_got[c] = 0;
        end else if (in_valid && !(m_have_last && int'(in_index) == m_last)) begin
            bit all_got;
            m_have_last = 1;
            m_last      = int'(in_index);
            all_got     = 1;
            for (int c = 0; c < NUM_CH; c++) begin
                int tgt;
                tgt = tbl[m_point*NUM_CH + c];
                if (!m_got[c] && int'(in_index) == tgt) begin
                    m_got[c] = 1;
                    m_cap[c] = longint'($signed(in_data[c*DATA_W +: DATA_W]));
                end else if (!m_got[c] && int'(in_index) > tgt) begin
                    m_got[c] = 1;
                    m_cap[c] = 0;
                    exp_miss = 1;
                end
                all_got = all_got && m_got[c];
            end
            if (all_got) begin
                exp_valid = 1;
                exp_sum   = 0;
                foreach (m_cap[c]) exp_sum += m_cap[c];
                exp_point = m_point;
                foreach (m_got[c]) m_got[c] = 0;
                if (m_point == NUM_POINTS - 1) begin
                    exp_frame_done = 1; m_run = 0; m_done = 1; m_point = 0;
                end else begin
                    m_point++;
                end
            end
        end
        exp_busy = m_run;
    end

    // Per-cycle comparison against the model, plus a log of emitted points.
    longint seen_sum[$];
    int     seen_point[$];
    bit     seen_fd[$];

    always @(negedge clk) begin
        check("out_valid", out_valid, exp_valid);
        check("frame_done", frame_done, exp_frame_done);
        check("busy", busy, exp_busy);
        check("miss_err", miss_err, exp_miss);
        if (exp_valid) begin
            check("out_sum", out_sum, exp_sum);
            check("out_point", out_point, exp_point);
        end
        if (out_valid === 1'b1) begin
            seen_sum.push_back(longint'(out_sum));
            seen_point.push_back(int'(out_point));
            seen_fd.push_back(frame_done);
        end
    end

    function automatic longint got_sum(input int i);
        return (seen_sum.size() > i) ? seen_sum[i] : -999999;
    endfunction

    function automatic int got_point(input int i);
        return (seen_point.size() > i) ? seen_point[i] : -1;
    endfunction

    // data[c] = (c+1)*(100+index): gives the 1000+... sums of the test plan.
    function automatic logic [NUM_CH*DATA_W-1:0] pattern(input int idx);
        logic [NUM_CH*DATA_W-1:0] p;
        for (int c = 0; c < NUM_CH; c++) p[c*DATA_W +: DATA_W] = 16'((c + 1) * (100 + idx));
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input int val);
        cfg_we = 1; cfg_addr = 6'(addr); cfg_data = 16'(val);
        tick();
        cfg_we = 0;
    endtask

    task automatic write_row(input int k, input int v0, input int v1, input int v2, input int v3);
        write_entry(k*NUM_CH + 0, v0);
        write_entry(k*NUM_CH + 1, v1);
        write_entry(k*NUM_CH + 2, v2);
        write_entry(k*NUM_CH + 3, v3);
    endtask

    task automatic send_raw(input int idx, input logic [NUM_CH*DATA_W-1:0] d);
        in_valid = 1; in_index = 16'(idx); in_data = d;
        tick();
        in_valid = 0;
    endtask

    task automatic stream(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_raw(i, pattern(i));
    endtask

    task automatic clear_log();
        seen_sum.delete(); seen_point.delete(); seen_fd.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1; start = 0; in_valid = 0; in_index = 0; in_data = 0;
        cfg_we = 0; cfg_addr = 0; cfg_data = 0;
        repeat (2) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_point", out_point, 0);
        check("rst_busy", busy, 0);
        reset = 0;

        for (int k = 0; k < NUM_POINTS; k++)
            for (int c = 0; c < NUM_CH; c++)
                write_entry(k*NUM_CH + c, (k == 0) ? 5 + c : (k == 1) ? 10 + c : 10*k + 5 + c);

        // Basic two-point capture over a linear index stream.
        clear_log(); start = 1; tick();
        stream(0, 20);
        start = 0; tick(); tick();
        check("t1_count", seen_sum.size(), 2);
        check("t1_sum0", got_sum(0), 1070);
        check("t1_sum1", got_sum(1), 1120);
        check("t1_point1", got_point(1), 1);

        // Repeated index: only the first copy is a sample.
        write_row(0, 9, 9, 9, 9);
        write_row(1, 9, 11, 12, 13);
        clear_log(); start = 1; tick();
        send_raw(9, {16'd40, 16'd30, 16'd20, 16'd10});
        send_raw(9, {16'd4, 16'd3, 16'd2, 16'd1});
        send_raw(9, {16'd4, 16'd3, 16'd2, 16'd1});
        tick();
        check("t2_one_pulse", seen_sum.size(), 1);
        check("t2_sum", got_sum(0), 100);
        stream(11, 13); tick();
        check("t2_guard_sum", got_sum(1), 1010);
        check("t2_guard_miss", miss_err, 1);
        start = 0; tick();

        // Missed target: channel 2 contributes zero, point still completes.
        write_row(0, 6, 7, 4, 8);
        write_row(1, 10, 11, 12, 13);
        clear_log(); start = 1; tick();
        check("t3_miss_cleared", miss_err, 0);
        stream(6, 8); tick();
        check("t3_count", seen_sum.size(), 1);
        check("t3_sum", got_sum(0), 752);
        check("t3_miss", miss_err, 1);
        start = 0; tick();

        // Abort mid-point, then restart from point 0.
        write_row(0, 5, 6, 7, 8);
        clear_log(); start = 1; tick();
        stream(5, 6);
        start = 0; tick();
        check("t4_busy_after_abort", busy, 0);
        check("t4_no_output", seen_sum.size(), 0);
        start = 1; tick();
        stream(0, 8); tick();
        check("t4_restart_sum", got_sum(0), 1070);
        check("t4_restart_point", got_point(0), 0);
        start = 0; tick();

        // Full frame, with a table write attempted while running.
        clear_log(); start = 1; tick();
        for (int i = 0; i <= 160; i++) begin
            if (i == 50) begin cfg_we = 1; cfg_addr = 0; cfg_data = 3; end
            send_raw(i, pattern(i));
            cfg_we = 0;
        end
        tick();
        check("t5_count", seen_sum.size(), NUM_POINTS);
        for (int k = 0; k < seen_point.size(); k++) check("t5_point_seq", seen_point[k], k);
        check("t5_fd_last", (seen_fd.size() == NUM_POINTS) ? seen_fd[NUM_POINTS-1] : 0, 1);
        check("t5_fd_first", (seen_fd.size() > 0) ? seen_fd[0] : 1, 0);
        check("t5_sum15", got_sum(15), 2570);
        check("t5_busy_done", busy, 0);
        start = 0; tick();
        clear_log(); start = 1; tick();
        stream(0, 8); tick();
        check("t5_table_kept", got_sum(0), 1070);
        start = 0; tick();

        // Table write on the start edge is used by that frame.
        clear_log(); start = 1; cfg_we = 1; cfg_addr = 0; cfg_data = 6; tick();
        cfg_we = 0;
        stream(0, 8); tick();
        check("t5_write_on_start", got_sum(0), 1071);
        start = 0; tick();

        // Most-negative samples, then reset mid-frame.
        write_row(0, 5, 6, 7, 8);
        clear_log(); start = 1; tick();
        for (int i = 5; i <= 8; i++) send_raw(i, {4{16'h8000}});
        tick();
        check("t6_neg_sum", got_sum(0), -131072);
        stream(10, 11);
        reset = 1; tick();
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_sum", out_sum, 0);
        check("t6_rst_point", out_point, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_fd", frame_done, 0);
        check("t6_rst_miss", miss_err, 0);
        reset = 0; start = 0; tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
